rgb2ycbcr_stream: RTL and testbench



---
 rtl/rgb2ycbcr_pkg.sv | 34 +++
 rtl/rgb2ycbcr_sat.sv | 40 ++++
 rtl/rgb2ycbcr_stream.sv | 149 ++++++++++++++
 tb/tb_rgb2ycbcr_stream.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb2ycbcr_pkg.sv
// rtl/rgb2ycbcr_pkg.sv - mode encodings, BT.601/BT.709 coefficient tables and pipeline sideband type
package rgb2ycbcr_pkg;

  localparam logic MODE_BT601 = 1'b0;
  localparam logic MODE_BT709 = 1'b1;

  localparam int CW = 12;
  typedef logic signed [CW-1:0] coef_t;

  // Rows Y, Cb, Cr; each row ordered R, G, B; scale 2^10.
  localparam coef_t COEF_601 [9] = '{
    12'sd306,  12'sd601,  12'sd117,
    -12'sd173, -12'sd339, 12'sd512,
    12'sd512,  -12'sd429, -12'sd83
  };

  localparam coef_t COEF_709 [9] = '{
    12'sd218,  12'sd732,  12'sd74,
    -12'sd117, -12'sd395, 12'sd512,
    12'sd512,  -12'sd465, -12'sd47
  };

  typedef struct packed {
    logic valid;
    logic sof;
    logic eol;
    logic mode;
  } sb_t;

  function automatic coef_t coef(input logic m, input int idx);
    return (m == MODE_BT709) ? COEF_709[idx] : COEF_601[idx];
  endfunction

endpackage

// File: rtl/rgb2ycbcr_sat.sv
// rtl/rgb2ycbcr_sat.sv - drop fractional bits and clamp one channel to [0, 2^DW-1]
// RGB2YCBCR_CLIP_STATS_EN adds the clip flag output.
module rgb2ycbcr_sat
  import rgb2ycbcr_pkg::*;
#(
  parameter int DW   = 10,
  parameter int FRAC = 10,
  parameter int SW   = DW + FRAC + 4
) (
  input  logic signed [SW-1:0] sum,
  output logic        [DW-1:0] val
`ifdef RGB2YCBCR_CLIP_STATS_EN
  ,
  output logic                 clip
`endif
);

  logic signed [SW-1:0] shifted;
  logic                 neg;
  logic                 over;

  always_comb begin
    shifted = sum >>> FRAC;
    neg     = sum[SW-1];
    // Any set bit above DW on a non-negative value means the result exceeds full scale.
    over    = !neg && (|shifted[SW-1:DW]);
    if (neg) begin
      val = '0;
    end else if (over) begin
      val = '1;
    end else begin
      val = shifted[DW-1:0];
    end
  end

`ifdef RGB2YCBCR_CLIP_STATS_EN
  assign clip = neg | over;
`endif

endmodule

// File: rtl/rgb2ycbcr_stream.sv
// rtl/rgb2ycbcr_stream.sv - 3-stage streaming RGB to YCbCr converter with backpressure
// RGB2YCBCR_CLIP_STATS_EN adds the clip_cnt saturation statistics output.
module rgb2ycbcr_stream
  import rgb2ycbcr_pkg::*;
#(
  parameter int DW   = 10,
  parameter int FRAC = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_r,
  input  logic [DW-1:0] in_g,
  input  logic [DW-1:0] in_b,
  input  logic          in_sof,
  input  logic          in_eol,
  input  logic          mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_y,
  output logic [DW-1:0] out_cb,
  output logic [DW-1:0] out_cr,
  output logic          out_sof,
  output logic          out_eol
`ifdef RGB2YCBCR_CLIP_STATS_EN
  ,
  output logic [15:0]   clip_cnt
`endif
);

  localparam int PW = DW + FRAC + 2;
  localparam int SW = DW + FRAC + 4;
  localparam logic signed [SW-1:0] RND = SW'(1) << (FRAC - 1);
  localparam logic signed [SW-1:0] OFF = SW'(1) << (DW + FRAC - 1);

  logic                 en;
  logic                 mode_reg;
  logic                 mode_eff;
  sb_t                  in_sb;
  sb_t                  s1;
  sb_t                  s2;
  logic        [DW-1:0] pix     [3];
  logic signed [PW-1:0] prod    [9];
  logic signed [SW-1:0] sum     [3];
  logic        [DW-1:0] sat_val [3];
`ifdef RGB2YCBCR_CLIP_STATS_EN
  logic        [2:0]    sat_clip;
  logic        [2:0]    out_clip;
  logic        [15:0]   inc;
`endif

  function automatic logic signed [PW-1:0] mul(input logic [DW-1:0] p, input coef_t c);
    logic signed [PW-1:0] pe;
    logic signed [PW-1:0] ce;
    pe = $signed({{(PW-DW){1'b0}}, p});
    ce = $signed({{(PW-CW){c[CW-1]}}, c});
    return pe * ce;
  endfunction

  function automatic logic signed [SW-1:0] ext(input logic signed [PW-1:0] p);
    return $signed({{(SW-PW){p[PW-1]}}, p});
  endfunction

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign pix[0]   = in_r;
  assign pix[1]   = in_g;
  assign pix[2]   = in_b;

  // mode_reg only commits once an SOF leaves S2, so younger in-flight SOFs are forwarded.
  always_comb begin
    mode_eff = mode_reg;
    if (s2.valid && s2.sof) mode_eff = s2.mode;
    if (s1.valid && s1.sof) mode_eff = s1.mode;
    if (in_sof) mode_eff = mode;
    in_sb = '{valid: in_valid, sof: in_sof, eol: in_eol, mode: mode_eff};
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 9; i++) begin
        prod[i] <= mul(pix[i % 3], coef(mode_eff, i));
      end
      for (int c = 0; c < 3; c++) begin
        sum[c] <= ext(prod[3*c]) + ext(prod[3*c+1]) + ext(prod[3*c+2])
                  + ((c == 0) ? RND : RND + OFF);
      end
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_sat
    rgb2ycbcr_sat #(.DW(DW), .FRAC(FRAC), .SW(SW)) u_sat (
      .sum (sum[c]),
      .val (sat_val[c])
`ifdef RGB2YCBCR_CLIP_STATS_EN
      ,
      .clip(sat_clip[c])
`endif
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= '0;
      s2        <= '0;
      mode_reg  <= MODE_BT601;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_y     <= '0;
      out_cb    <= '0;
      out_cr    <= '0;
    end else if (en) begin
      s1        <= in_sb;
      s2        <= s1;
      out_valid <= s2.valid;
      out_sof   <= s2.sof;
      out_eol   <= s2.eol;
      out_y     <= sat_val[0];
      out_cb    <= sat_val[1];
      out_cr    <= sat_val[2];
      if (s2.valid && s2.sof) mode_reg <= s2.mode;
    end
  end

`ifdef RGB2YCBCR_CLIP_STATS_EN
  assign inc = 16'(out_clip[0]) + 16'(out_clip[1]) + 16'(out_clip[2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_clip <= '0;
      clip_cnt <= '0;
    end else begin
      if (en) out_clip <= sat_clip;
      if (out_valid && out_ready) begin
        if (out_sof) begin
          clip_cnt <= inc;
        end else if (clip_cnt > 16'hFFFF - inc) begin
          clip_cnt <= 16'hFFFF;
        end else begin
          clip_cnt <= clip_cnt + inc;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_rgb2ycbcr_stream.sv
// tb/tb_rgb2ycbcr_stream.sv - directed vector bench for rgb2ycbcr_stream
// Covers clip_cnt when RGB2YCBCR_CLIP_STATS_EN is defined.
module tb_rgb2ycbcr_stream;

  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_r, in_g, in_b;
  logic          in_sof, in_eol, mode;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_y, out_cb, out_cr;
  logic          out_sof, out_eol;
`ifdef RGB2YCBCR_CLIP_STATS_EN
  logic [15:0]   clip_cnt;
  int            clip_model = 0;
`endif

  always #5 clk = ~clk;

  rgb2ycbcr_stream #(.DW(DW), .FRAC(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_r     (in_r),
    .in_g     (in_g),
    .in_b     (in_b),
    .in_sof   (in_sof),
    .in_eol   (in_eol),
    .mode     (mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .out_cb   (out_cb),
    .out_cr   (out_cr),
    .out_sof  (out_sof),
    .out_eol  (out_eol)
`ifdef RGB2YCBCR_CLIP_STATS_EN
    ,
    .clip_cnt (clip_cnt)
`endif
  );

  typedef struct {
    int r, g, b;
    int sof, eol, md;
    int y, cb, cr;
    int nclip;
  } vec_t;

  vec_t vt [12];
  int   applied = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int px(input int i);
    return 50 * i + 7;
  endfunction

  task automatic apply_vec(input int i);
    int lat;
    @(negedge clk);
    check($sformatf("v%0d in_ready", i), in_ready, 1);
    in_valid = 1'b1;
    in_r     = DW'(vt[i].r);
    in_g     = DW'(vt[i].g);
    in_b     = DW'(vt[i].b);
    in_sof   = 1'(vt[i].sof);
    in_eol   = 1'(vt[i].eol);
    mode     = 1'(vt[i].md);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eol   = 1'b0;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("v%0d latency", i), lat, 3);
    check($sformatf("v%0d y", i), out_y, vt[i].y);
    check($sformatf("v%0d cb", i), out_cb, vt[i].cb);
    check($sformatf("v%0d cr", i), out_cr, vt[i].cr);
    check($sformatf("v%0d sof", i), out_sof, vt[i].sof);
    check($sformatf("v%0d eol", i), out_eol, vt[i].eol);
`ifdef RGB2YCBCR_CLIP_STATS_EN
    clip_model = (vt[i].sof != 0) ? vt[i].nclip : clip_model + vt[i].nclip;
    @(negedge clk);
    check($sformatf("v%0d clip_cnt", i), clip_cnt, clip_model);
`endif
  endtask

  task automatic stream_test();
    int got = 0;
    int cyc = 0;
    int guard;
    int tail;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          in_valid = 1'b1;
          in_r     = DW'(px(i));
          in_g     = DW'(px(i));
          in_b     = DW'(px(i));
          in_sof   = (i == 0);
          in_eol   = (i % 5 == 4);
          mode     = 1'b0;
          guard    = 0;
          while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
          end
          @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eol   = 1'b0;
      end
      begin
        while (got < 20 && cyc < 400) begin
          @(negedge clk);
          cyc++;
          if (out_valid && out_ready) begin
            check($sformatf("px%0d y", got), out_y, px(got));
            check($sformatf("px%0d cb", got), out_cb, 512);
            check($sformatf("px%0d cr", got), out_cr, 512);
            check($sformatf("px%0d sof", got), out_sof, (got == 0));
            check($sformatf("px%0d eol", got), out_eol, (got % 5 == 4));
            got++;
            if (got == 8) begin
              @(posedge clk);
              #1 out_ready = 1'b0;
              for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                check($sformatf("stall%0d in_ready", k), in_ready, 0);
                check($sformatf("stall%0d out_valid", k), out_valid, 1);
                check($sformatf("stall%0d y", k), out_y, px(8));
                check($sformatf("stall%0d sof/eol", k), {out_sof, out_eol}, 0);
              end
              @(posedge clk);
              #1 out_ready = 1'b1;
            end
          end
        end
        check("stream pixel count", got, 20);
      end
    join
    tail = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid) tail++;
    end
    check("stream extra beats", tail, 0);
  endtask

  task automatic reset_test();
    int stale = 0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      in_valid = 1'b1;
      in_r     = '0;
      in_g     = '0;
      in_b     = DW'(1023);
      in_sof   = (i == 0);
      in_eol   = 1'b0;
      mode     = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    check("rst pre out_valid", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst out_valid", out_valid, 0);
    check("rst out_y", out_y, 0);
    check("rst out_cb", out_cb, 0);
    check("rst in_ready", in_ready, 1);
    out_ready = 1'b1;
`ifdef RGB2YCBCR_CLIP_STATS_EN
    clip_model = 0;
    check("rst clip_cnt", clip_cnt, 0);
`endif
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rst stale beats", stale, 0);
    apply_vec(11);
  endtask

  task automatic bubble_test();
    int exp_v;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      exp_v = (k >= 3 && (k - 3) % 2 == 0 && (k - 3) / 2 < 6) ? 1 : 0;
      check($sformatf("bub%0d out_valid", k), out_valid, exp_v);
      if (exp_v != 0) begin
        check($sformatf("bub%0d y", k), out_y, 100 + 37 * ((k - 3) / 2));
      end
      if (k < 12 && k % 2 == 0) begin
        in_valid = 1'b1;
        in_r     = DW'(100 + 37 * (k / 2));
        in_g     = DW'(100 + 37 * (k / 2));
        in_b     = DW'(100 + 37 * (k / 2));
        in_sof   = (k == 0);
        mode     = 1'b0;
      end else begin
        in_valid = 1'b0;
        in_sof   = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{r: 1023, g: 1023, b: 1023, sof: 1, eol: 0, md: 0, y: 1023, cb: 512,  cr: 512,  nclip: 0};
    vt[1]  = '{r: 0,    g: 0,    b: 0,    sof: 0, eol: 1, md: 0, y: 0,    cb: 512,  cr: 512,  nclip: 0};
    vt[2]  = '{r: 1023, g: 0,    b: 0,    sof: 0, eol: 0, md: 0, y: 306,  cb: 339,  cr: 1023, nclip: 1};
    vt[3]  = '{r: 0,    g: 1023, b: 0,    sof: 0, eol: 0, md: 0, y: 600,  cb: 173,  cr: 83,   nclip: 0};
    vt[4]  = '{r: 0,    g: 0,    b: 1023, sof: 0, eol: 1, md: 0, y: 117,  cb: 1023, cr: 429,  nclip: 1};
    vt[5]  = '{r: 0,    g: 0,    b: 1023, sof: 1, eol: 0, md: 1, y: 74,   cb: 1023, cr: 465,  nclip: 1};
    vt[6]  = '{r: 0,    g: 0,    b: 1023, sof: 0, eol: 0, md: 0, y: 74,   cb: 1023, cr: 465,  nclip: 1};
    vt[7]  = '{r: 1023, g: 0,    b: 0,    sof: 0, eol: 1, md: 0, y: 218,  cb: 395,  cr: 1023, nclip: 1};
    vt[8]  = '{r: 0,    g: 1023, b: 0,    sof: 1, eol: 0, md: 0, y: 600,  cb: 173,  cr: 83,   nclip: 0};
    vt[9]  = '{r: 0,    g: 1023, b: 0,    sof: 1, eol: 0, md: 1, y: 731,  cb: 117,  cr: 47,   nclip: 0};
    vt[10] = '{r: 100,  g: 200,  b: 300,  sof: 1, eol: 1, md: 0, y: 182,  cb: 579,  cr: 454,  nclip: 0};
    vt[11] = '{r: 0,    g: 0,    b: 1023, sof: 0, eol: 0, md: 1, y: 117,  cb: 1023, cr: 429,  nclip: 1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_r      = '0;
    in_g      = '0;
    in_b      = '0;
    in_sof    = 1'b0;
    in_eol    = 1'b0;
    mode      = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset out_y", out_y, 0);
    check("reset out_cb", out_cb, 0);
    check("reset out_cr", out_cr, 0);
    check("reset sof/eol", {out_sof, out_eol}, 0);
    check("reset in_ready", in_ready, 1);
`ifdef RGB2YCBCR_CLIP_STATS_EN
    check("reset clip_cnt", clip_cnt, 0);
`endif

    for (int i = 0; i < 11; i++) apply_vec(i);

    stream_test();
    reset_test();
    bubble_test();

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
